instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//   Sequencer directly upstream of the 16-bit instruction register. On a Start request it reads
//   one instruction as two bytes from byte-wide instruction memory, little-endian (LSB at PC, MSB at PC+1).
//   It drives the register's byte input, write strobe and byte-select, owns the program counter,
//   and signals completion to the control unit.
// PARAMETERS
//   ADDR_W    8    width of program counter / memory address
//   RESET_PC  0    PC value loaded on Reset (ADDR_W bits)
// PORTS
//   Clock        in   1       system clock, all state updates on rising edge
//   Reset        in   1       synchronous, active-high reset
//   Start        in   1       request one instruction fetch (sampled in IDLE only)
//   PCLoad       in   1       load PC from PCLoadValue (honoured in IDLE only)
//   PCLoadValue  in   ADDR_W  jump/branch target
//   MemAddr      out  ADDR_W  instruction memory byte address (= PC)
//   MemRdEn      out  1       memory read request
//   MemData      in   8       memory read data, valid when MemReady=1
//   MemReady     in   1       memory data-valid handshake (may stall any number of cycles)
//   IRData       out  8       byte to instruction register
//   IRWrite      out  1       instruction register write strobe
//   IRLH         out  1       0 = LSB byte, 1 = MSB byte
//   PC           out  ADDR_W  current program counter
//   Busy         out  1       high in FETCH_L, FETCH_H
//   Done         out  1       one-cycle pulse: full instruction written
// BEHAVIOUR
//   Reset (any state, incl. mid-fetch): state=IDLE, PC=RESET_PC; all outputs 0 except PC, MemAddr=RESET_PC.
//   FSM states: IDLE, FETCH_L, FETCH_H, DONE.
//   IDLE:    PCLoad=1 -> PC<=PCLoadValue, stay IDLE (PCLoad wins over simultaneous Start);
//            else Start=1 -> FETCH_L; else stay.
//   FETCH_L: MemRdEn=1, MemAddr=PC. MemReady=0 -> hold. MemReady=1 -> IRWrite=1, IRLH=0,
//            IRData=MemData (same cycle, combinational), PC<=PC+1, -> FETCH_H.
//   FETCH_H: as FETCH_L with IRLH=1; on MemReady=1 PC<=PC+1, -> DONE.
//   DONE:    Done=1 for exactly one cycle, -> IDLE. Start in DONE is ignored.
//   IRWrite/IRLH/IRData are Mealy outputs; IR captures on the same edge the FSM advances.
//   Outside write cycles: IRWrite=0, IRLH=0, IRData=0; MemRdEn=0 in IDLE/DONE.
//   Start and PCLoad while Busy or in DONE are ignored (no queueing).
//   PC arithmetic modulo 2^ADDR_W: PC=all-ones fetches LSB there, MSB at 0, ends at PC=1.
//   Latency (MemReady held 1): Start sampled edge 0; LSB written edge 1; MSB written edge 2;
//   Done high in cycle after edge 2; Start-to-Done = 3 cycles. Each wait cycle adds 1.
//   MemData ignored whenever MemReady=0; no timeout.
// STRUCTURE
//   Shared package/header fetch_pkg: state encodings (IDLE=2'd0, FETCH_L=2'd1, FETCH_H=2'd2, DONE=2'd3),
//   IRLH_LSB/IRLH_MSB constants.
//   One natural sub-module: pc_counter (sync reset to RESET_PC, load, increment, wrap).
//   FSM and Mealy output logic in the top.
// TESTING
//   Reset then idle 5 cycles -> PC=0, Busy=0, Done=0, IRWrite=0, MemRdEn=0.
//   Fetch, mem[0]=0x34 mem[1]=0x12, MemReady=1 -> IR=0x1234, PC=2, Done 3 cycles after Start, single pulse.
//   Same fetch with MemReady low 2 cycles before each byte -> IR=0x1234, Done 7 cycles after Start,
//   IRWrite only when MemReady=1.
//   ADDR_W=8, PCLoad 0xFF then Start, mem[0xFF]=0xCD mem[0x00]=0xAB -> IR=0xABCD, PC=0x01.
//   PCLoad=1 and Start=1 together in IDLE with PCLoadValue=0x40 -> PC=0x40, no fetch; later Start fetches 0x40/0x41.
//   Reset asserted in FETCH_H; Start pulsed while Busy -> after Reset: IDLE, PC=RESET_PC, no Done;
//   mid-fetch Start has no effect.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encodings
// and the byte-select values driven to the instruction register.
package fetch_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FETCH_L = 2'd1;
    localparam logic [1:0] FETCH_H = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic IRLH_LSB = 1'b0;
    localparam logic IRLH_MSB = 1'b1;

    // True for the two states that own the memory port.
    function automatic logic is_fetch_state(input logic [1:0] s);
        return (s == FETCH_L) || (s == FETCH_H);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Byte-wide instruction memory port between the fetch unit and memory.
// Handshake: the fetch unit holds MemRdEn=1 with a stable MemAddr until the
// memory answers MemReady=1; MemData is only meaningful in a cycle where
// MemReady=1, and exactly one byte is consumed per such cycle. MemReady may
// stay low for any number of cycles.
interface instruction_fetch_unit_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] MemAddr;
    logic              MemRdEn;
    logic [7:0]        MemData;
    logic              MemReady;

    modport master (
        output MemAddr,
        output MemRdEn,
        input  MemData,
        input  MemReady
    );

    modport slave (
        input  MemAddr,
        input  MemRdEn,
        output MemData,
        output MemReady
    );
endinterface

// File: rtl/instruction_fetch_unit_pc_counter.sv
// Program counter: synchronous reset to RESET_PC, parallel load, and
// increment that wraps modulo 2^ADDR_W.
module pc_counter #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Load,
    input  logic [ADDR_W-1:0] LoadValue,
    input  logic              Inc,
    output logic [ADDR_W-1:0] Count
);

    // Load has priority over increment; the top never asserts both together.
    always_ff @(posedge Clock) begin
        if (Reset)
            Count <= RESET_PC;
        else if (Load)
            Count <= LoadValue;
        else if (Inc)
            Count <= Count + 1'b1;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch sequencer: on Start reads two bytes (LSB at PC, MSB at
// PC+1) and streams them into the 16-bit instruction register, then pulses
// Done for one cycle. IR write signals are Mealy outputs so the register
// captures on the same edge the FSM advances.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Start,
    input  logic                      PCLoad,
    input  logic [ADDR_W-1:0]         PCLoadValue,
    instruction_fetch_unit_if.master  mem,
    output logic [7:0]                IRData,
    output logic                      IRWrite,
    output logic                      IRLH,
    output logic [ADDR_W-1:0]         PC,
    output logic                      Busy,
    output logic                      Done,
    output logic [1:0]                State
);

    logic [1:0] state;
    logic [1:0] state_next;
    logic       byte_write;
    logic       pc_load;

    // Registered FSM state.
    always_ff @(posedge Clock) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next state: Start/PCLoad are only looked at in IDLE, PCLoad winning.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!PCLoad && Start) state_next = FETCH_L;
            FETCH_L: if (mem.MemReady)     state_next = FETCH_H;
            FETCH_H: if (mem.MemReady)     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Mealy outputs: a byte is written in any fetch cycle the memory answers.
    always_comb begin
        Busy        = is_fetch_state(state);
        byte_write  = Busy && mem.MemReady;
        pc_load     = (state == IDLE) && PCLoad;
        mem.MemRdEn = Busy;
        mem.MemAddr = PC;
        IRWrite     = byte_write;
        IRLH        = (byte_write && state == FETCH_H) ? IRLH_MSB : IRLH_LSB;
        IRData      = byte_write ? mem.MemData : 8'h00;
        Done        = (state == DONE);
        State       = state;
    end

    pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .Clock     (Clock),
        .Reset     (Reset),
        .Load      (pc_load),
        .LoadValue (PCLoadValue),
        .Inc       (byte_write),
        .Count     (PC)
    );

endmodule
